// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM request arbiter: FSM states, the per-channel
// request slot and channel/address limits.
package sdram_arb_pkg;

   localparam int NCH_MAX  = 8;
   localparam int ADDR_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   // One latched request; addr is sized for the widest supported AW.
   typedef struct packed {
      logic [ADDR_MAX-1:0] addr;
      logic                we;
      logic                burst;
      logic [15:0]         wdata;
      logic [1:0]          bs;
   } slot_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational grant selection. Default: lowest requesting index wins.
// With SDRAM_ARB_ROUND_ROBIN_EN defined: first requester at or after i_ptr.
module sdram_arb_pick #(
   parameter int NCH = 4,
   parameter int PW  = 2
) (
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   input  logic [PW-1:0]  i_ptr,
`endif
   input  logic [NCH-1:0] i_req,
   output logic [NCH-1:0] o_grant,
   output logic           o_valid
);

   // Pick exactly one requester and flag whether any was found.
   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
      o_grant = '0;
      o_valid = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NCH; k++) begin
         for (int i = 0; i < NCH; i++) begin
            if (!o_valid && i_req[i] && (((int'(i_ptr) + k) % NCH) == i)) begin
               o_grant[i] = 1'b1;
               o_valid    = 1'b1;
            end
         end
      end
`else
      for (int i = 0; i < NCH; i++) begin
         if (!o_valid && i_req[i]) begin
            o_grant[i] = 1'b1;
            o_valid    = 1'b1;
         end
      end
`endif
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-channel SDRAM request arbiter. Each channel raises REQ_TRIG to post a
// request; one transfer at a time is handed to the SDRAM controller through
// a registered IDLE/ISSUE/WAIT handshake on SDRAM_READY.
// Optional build macro: SDRAM_ARB_ROUND_ROBIN_EN (rotating-pointer grant).
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NCH = 4,
   parameter int AW  = 26,
   parameter int DW  = 64
) (
   input  logic              CLK,
   input  logic              nRESET,
   input  logic [NCH-1:0]    REQ_TRIG,
   input  logic [NCH*AW-1:0] REQ_ADDR,
   input  logic [NCH-1:0]    REQ_WE,
   input  logic [NCH-1:0]    REQ_BURST,
   input  logic [NCH*16-1:0] REQ_WDATA,
   input  logic [NCH*2-1:0]  REQ_BS,
   output logic [NCH*DW-1:0] CH_RDATA,
   output logic [NCH-1:0]    CH_DONE,
   output logic [NCH-1:0]    CH_BUSY,
   output logic              SDRAM_RD,
   output logic              SDRAM_WR,
   output logic              SDRAM_BURST,
   output logic [AW-1:0]     SDRAM_ADDR,
   output logic [15:0]       SDRAM_DIN,
   output logic [1:0]        SDRAM_BS,
   input  logic [DW-1:0]     SDRAM_DOUT,
   input  logic              SDRAM_READY
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   arb_state_t     r_state;
   logic [NCH-1:0] r_trig_prev;
   logic           r_old_ready;
   logic [NCH-1:0] r_pending;
   logic [NCH-1:0] r_running;
   logic [NCH-1:0] r_done;
   logic [PW-1:0]  r_gidx;
   logic           r_is_wr;
   logic           r_rd;
   logic           r_wr;
   logic           r_burst;
   logic [AW-1:0]  r_addr;
   logic [15:0]    r_din;
   logic [1:0]     r_bs;
   slot_t          r_slot  [NCH];
   logic [DW-1:0]  r_rdata [NCH];

   slot_t          w_in    [NCH];
   slot_t          w_eff   [NCH];
   logic [NCH-1:0] w_edge;
   logic [NCH-1:0] w_req;
   logic [NCH-1:0] w_grant;
   logic           w_grant_valid;
   logic [PW-1:0]  w_gidx;
   logic           w_grant_now;

   assign w_edge      = ~r_trig_prev & REQ_TRIG;
   assign w_req       = r_pending | w_edge;
   assign w_grant_now = (r_state == ST_IDLE) && SDRAM_READY && w_grant_valid;

   // Unpack the flat request buses; a channel edging this cycle bypasses its slot.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_in[i].addr  = ADDR_MAX'(REQ_ADDR[i*AW +: AW]);
         w_in[i].we    = REQ_WE[i];
         w_in[i].burst = REQ_BURST[i];
         w_in[i].wdata = REQ_WDATA[i*16 +: 16];
         w_in[i].bs    = REQ_BS[i*2 +: 2];
         w_eff[i]      = w_edge[i] ? w_in[i] : r_slot[i];
      end
   end

   // One-hot grant to channel index.
   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant[i]) w_gidx = PW'(i);
      end
   end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   logic [PW-1:0] r_ptr;

   // Rotate the search start to just past the channel granted last.
   always_ff @(posedge CLK) begin
      if (!nRESET)
         r_ptr <= '0;
      else if (w_grant_now)
         r_ptr <= (w_gidx == PW'(NCH-1)) ? '0 : w_gidx + PW'(1);
   end

   sdram_arb_pick #(.NCH(NCH), .PW(PW)) u_pick (
      .i_ptr   (r_ptr),
      .i_req   (w_req),
      .o_grant (w_grant),
      .o_valid (w_grant_valid)
   );
`else
   sdram_arb_pick #(.NCH(NCH), .PW(PW)) u_pick (
      .i_req   (w_req),
      .o_grant (w_grant),
      .o_valid (w_grant_valid)
   );
`endif

   // Trigger and ready history; loaded even in reset so release creates no false edge.
   always_ff @(posedge CLK) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      r_trig_prev <= REQ_TRIG;
      r_old_ready <= SDRAM_READY;
   end

   // Latch request fields on each edge; a later edge simply overwrites the slot.
   always_ff @(posedge CLK) begin
      // NOTE: slot storage carries no reset; pending bits decide when its contents are meaningful.
      for (int i = 0; i < NCH; i++) begin
         if (w_edge[i]) r_slot[i] <= w_in[i];
      end
   end

   // Arbitration FSM with registered command outputs.
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_running <= '0;
         r_done    <= '0;
         r_gidx    <= '0;
         r_is_wr   <= 1'b0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_burst   <= 1'b0;
         r_addr    <= '0;
         r_din     <= '0;
         r_bs      <= 2'b11;
      end else begin
         r_done    <= '0;
         r_pending <= r_pending | w_edge;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_now) begin
                  r_pending <= (r_pending | w_edge) & ~w_grant;
                  r_running <= w_grant;
                  r_gidx    <= w_gidx;
                  r_addr    <= w_eff[w_gidx].addr[AW-1:0];
                  r_din     <= w_eff[w_gidx].wdata;
                  r_bs      <= w_eff[w_gidx].bs;
                  r_burst   <= w_eff[w_gidx].burst;
                  r_is_wr   <= w_eff[w_gidx].we;
                  r_rd      <= ~w_eff[w_gidx].we;
                  r_wr      <= w_eff[w_gidx].we;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (r_old_ready && !SDRAM_READY) begin
                  r_rd    <= 1'b0;
                  r_wr    <= 1'b0;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (SDRAM_READY) begin
                  r_done[r_gidx] <= 1'b1;
                  r_running      <= '0;
                  r_state        <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Capture read data on completion; kept across reset.
   always_ff @(posedge CLK) begin
      if (nRESET && (r_state == ST_WAIT) && SDRAM_READY && !r_is_wr)
         r_rdata[r_gidx] <= SDRAM_DOUT;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_rdata
      assign CH_RDATA[g*DW +: DW] = r_rdata[g];
   end

   assign CH_DONE     = r_done;
   assign CH_BUSY     = r_pending | r_running;
   assign SDRAM_RD    = r_rd;
   assign SDRAM_WR    = r_wr;
   assign SDRAM_BURST = r_burst;
   assign SDRAM_ADDR  = r_addr;
   assign SDRAM_DIN   = r_din;
   assign SDRAM_BS    = r_bs;

endmodule
